// File: rtl/melody_sequencer.sv
// Melody sequencer: steps a 16-entry writable note table into the square-wave
// generator's half-period input, holding each note for dur beats plus a fixed gap.
module melody_sequencer #(
   parameter int unsigned BEAT_CYCLES = 750000,
   parameter int unsigned GAP_CYCLES  = 12000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        play,
   input  logic        stop,
   input  logic        loop,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [6:0]  wr_data,
   output logic [14:0] half_period,
   output logic [2:0]  note,
   output logic [3:0]  step,
   output logic        busy,
   output logic        song_end
);
   localparam logic [19:0] BEAT_LD = 20'(BEAT_CYCLES);
   localparam logic [19:0] GAP_LD  = 20'(GAP_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NOTE, S_GAP} state_t;
   state_t state, state_nx;

   logic [6:0]  tbl [16];
   logic [3:0]  beat_cnt, beat_nx;
   logic [19:0] cyc_cnt, cyc_nx;
   logic [3:0]  step_nx;
   logic        end_nx, busy_nx;
   logic [14:0] hp_nx;
   logic [2:0]  note_nx;
   logic [2:0]  e_note;
   logic [3:0]  e_dur;

   assign e_note = tbl[step][6:4];
   assign e_dur  = tbl[step][3:0];

   function automatic logic [14:0] note_hp(input logic [2:0] code);
      case (code)
         3'd1:    note_hp = 15'd13636;
         3'd2:    note_hp = 15'd12145;
         3'd3:    note_hp = 15'd11472;
         3'd4:    note_hp = 15'd10221;
         3'd5:    note_hp = 15'd9104;
         3'd6:    note_hp = 15'd8595;
         3'd7:    note_hp = 15'd7662;
         default: note_hp = '0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         step        <= '0;
         beat_cnt    <= '0;
         cyc_cnt     <= '0;
         half_period <= '0;
         note        <= '0;
         busy        <= 1'b0;
         song_end    <= 1'b0;
         for (int unsigned i = 0; i < 16; i++) tbl[i] <= '0;
      end else begin
         state       <= state_nx;
         step        <= step_nx;
         beat_cnt    <= beat_nx;
         cyc_cnt     <= cyc_nx;
         half_period <= hp_nx;
         note        <= note_nx;
         busy        <= busy_nx;
         song_end    <= end_nx;
         if (wr_en) tbl[wr_addr] <= wr_data;
      end
   end

   // Note length is beats x BEAT_CYCLES: cycle counter reloads once per beat.
   always_comb begin
      state_nx = state;
      step_nx  = step;
      beat_nx  = beat_cnt;
      cyc_nx   = cyc_cnt;
      end_nx   = 1'b0;
      if (stop) begin
         state_nx = S_IDLE;
         step_nx  = '0;
         beat_nx  = '0;
         cyc_nx   = '0;
      end else if (play) begin
         state_nx = S_LOAD;
         step_nx  = '0;
         beat_nx  = '0;
         cyc_nx   = '0;
      end else begin
         case (state)
            S_IDLE: ;
            S_LOAD: begin
               if (e_dur != 4'd0) begin
                  state_nx = S_NOTE;
                  beat_nx  = e_dur;
                  cyc_nx   = BEAT_LD;
               end else if (loop && step != 4'd0) begin
                  step_nx = '0;
               end else begin
                  state_nx = S_IDLE;
                  step_nx  = '0;
                  end_nx   = 1'b1;
               end
            end
            S_NOTE: begin
               if (cyc_cnt <= 20'd1) begin
                  if (beat_cnt <= 4'd1) begin
                     state_nx = S_GAP;
                     beat_nx  = '0;
                     cyc_nx   = GAP_LD;
                  end else begin
                     beat_nx = beat_cnt - 4'd1;
                     cyc_nx  = BEAT_LD;
                  end
               end else begin
                  cyc_nx = cyc_cnt - 20'd1;
               end
            end
            S_GAP: begin
               if (cyc_cnt <= 20'd1) begin
                  cyc_nx = '0;
                  if (step != 4'd15) begin
                     step_nx  = step + 4'd1;
                     state_nx = S_LOAD;
                  end else if (loop) begin
                     step_nx  = '0;
                     state_nx = S_LOAD;
                  end else begin
                     step_nx  = '0;
                     state_nx = S_IDLE;
                     end_nx   = 1'b1;
                  end
               end else begin
                  cyc_nx = cyc_cnt - 20'd1;
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // Tone is latched on LOAD->NOTE so later table writes cannot disturb it.
   always_comb begin
      hp_nx   = '0;
      note_nx = '0;
      busy_nx = (state_nx != S_IDLE);
      if (state_nx == S_NOTE) begin
         if (state == S_LOAD) begin
            hp_nx   = note_hp(e_note);
            note_nx = e_note;
         end else begin
            hp_nx   = half_period;
            note_nx = note;
         end
      end
   end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: directed vector table, hand-written
// corner sequences and randomized traffic against a phase/remaining-time model.
module tb_melody_sequencer;
   localparam int unsigned BEAT = 4;
   localparam int unsigned GAP  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        play = 1'b0, stop = 1'b0, loop = 1'b0, wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [6:0]  wr_data = '0;
   logic [14:0] half_period;
   logic [2:0]  note;
   logic [3:0]  step;
   logic        busy, song_end;

   int total = 0;
   int bad   = 0;

   melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .play(play), .stop(stop), .loop(loop),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .half_period(half_period), .note(note), .step(step),
      .busy(busy), .song_end(song_end)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   int unsigned hp_tab [8] = '{0, 13636, 12145, 11472, 10221, 9104, 8595, 7662};

   // Reference model: playback phase plus cycles remaining in that phase.
   localparam int PH_IDLE = 0, PH_LOAD = 1, PH_NOTE = 2, PH_GAP = 3;
   int         m_ph, m_left, m_step;
   logic [2:0] m_cur;
   logic       m_end;
   logic [6:0] m_tbl [16];

   task automatic model_reset();
      m_ph = PH_IDLE; m_left = 0; m_step = 0; m_cur = '0; m_end = 1'b0;
      for (int i = 0; i < 16; i++) m_tbl[i] = '0;
   endtask

   task automatic model_edge();
      logic [6:0] e;
      m_end = 1'b0;
      if (stop) begin
         m_ph = PH_IDLE; m_step = 0;
      end else if (play) begin
         m_ph = PH_LOAD; m_step = 0;
      end else begin
         case (m_ph)
            PH_LOAD: begin
               e = m_tbl[m_step];
               if (e[3:0] != 4'd0) begin
                  m_ph = PH_NOTE; m_left = int'(e[3:0]) * int'(BEAT); m_cur = e[6:4];
               end else if (loop && m_step != 0) begin
                  m_step = 0;
               end else begin
                  m_ph = PH_IDLE; m_step = 0; m_end = 1'b1;
               end
            end
            PH_NOTE: begin
               m_left--;
               if (m_left == 0) begin m_ph = PH_GAP; m_left = int'(GAP); end
            end
            PH_GAP: begin
               m_left--;
               if (m_left == 0) begin
                  if (m_step < 15) begin m_step++; m_ph = PH_LOAD; end
                  else if (loop) begin m_step = 0; m_ph = PH_LOAD; end
                  else begin m_ph = PH_IDLE; m_step = 0; m_end = 1'b1; end
               end
            end
            default: ;
         endcase
      end
      if (wr_en) m_tbl[wr_addr] = wr_data;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("m_hp",   32'(half_period), (m_ph == PH_NOTE) ? hp_tab[m_cur] : 32'd0);
      check("m_note", 32'(note),        (m_ph == PH_NOTE) ? 32'(m_cur) : 32'd0);
      check("m_step", 32'(step),        32'(m_step));
      check("m_busy", 32'(busy),        32'(m_ph != PH_IDLE));
      check("m_end",  32'(song_end),    32'(m_end));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk); #1;
      check_model();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input int a, input int n, input int d);
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = {3'(n), 4'(d)};
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_play();
      play = 1'b1; tick(); play = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic base_song();
      wr(0, 3, 2); wr(1, 0, 1); wr(2, 7, 1); wr(3, 0, 0);
   endtask

   typedef struct {
      logic        p;
      int          edges;
      int unsigned hp;
      int unsigned nt;
      logic        bsy;
      logic        se;
      int unsigned st;
   } vec_t;
   vec_t vecs [14];

   int end_cyc, hcnt, ends, wraps;
   logic [3:0] prev_step;

   initial begin
      // Basic playback, one record per checkpoint; cycle k = k edges after the play edge.
      vecs[0]  = '{1'b1, 1, 0,     0, 1'b1, 1'b0, 0};  // 1  LOAD
      vecs[1]  = '{1'b0, 1, 11472, 3, 1'b1, 1'b0, 0};  // 2
      vecs[2]  = '{1'b0, 7, 11472, 3, 1'b1, 1'b0, 0};  // 9
      vecs[3]  = '{1'b0, 1, 0,     0, 1'b1, 1'b0, 0};  // 10 GAP
      vecs[4]  = '{1'b0, 2, 0,     0, 1'b1, 1'b0, 1};  // 12 LOAD
      vecs[5]  = '{1'b0, 1, 0,     0, 1'b1, 1'b0, 1};  // 13 rest
      vecs[6]  = '{1'b0, 3, 0,     0, 1'b1, 1'b0, 1};  // 16
      vecs[7]  = '{1'b0, 1, 0,     0, 1'b1, 1'b0, 1};  // 17 GAP
      vecs[8]  = '{1'b0, 3, 7662,  7, 1'b1, 1'b0, 2};  // 20
      vecs[9]  = '{1'b0, 3, 7662,  7, 1'b1, 1'b0, 2};  // 23
      vecs[10] = '{1'b0, 1, 0,     0, 1'b1, 1'b0, 2};  // 24
      vecs[11] = '{1'b0, 2, 0,     0, 1'b1, 1'b0, 3};  // 26 LOAD marker
      vecs[12] = '{1'b0, 1, 0,     0, 1'b0, 1'b1, 0};  // 27 song_end
      vecs[13] = '{1'b0, 1, 0,     0, 1'b0, 1'b0, 0};  // 28

      model_reset();
      #12;
      check("rst_hp", 32'(half_period), 0);
      check("rst_note", 32'(note), 0);
      check("rst_step", 32'(step), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_end", 32'(song_end), 0);
      @(posedge clk); #3; rst_n = 1'b1;
      run(2);

      base_song();
      loop = 1'b0;
      foreach (vecs[i]) begin
         play = vecs[i].p;
         tick();
         play = 1'b0;
         for (int k = 1; k < vecs[i].edges; k++) tick();
         check($sformatf("v%0d_hp", i), 32'(half_period), vecs[i].hp);
         check($sformatf("v%0d_note", i), 32'(note), vecs[i].nt);
         check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
         check($sformatf("v%0d_end", i), 32'(song_end), 32'(vecs[i].se));
         check($sformatf("v%0d_step", i), 32'(step), vecs[i].st);
      end

      // Looped playback, then loop dropped mid-song ends at the next marker.
      loop = 1'b1;
      pulse_play();
      run(25);
      check("lp26_busy", 32'(busy), 1);
      check("lp26_step", 32'(step), 3);
      tick();
      check("lp27_busy", 32'(busy), 1);
      check("lp27_step", 32'(step), 0);
      check("lp27_end", 32'(song_end), 0);
      tick();
      check("lp28_hp", 32'(half_period), 11472);
      loop = 1'b0;
      ends = 0;
      for (int i = 0; i < 30; i++) begin tick(); if (song_end) ends++; end
      check("lp_ends", 32'(ends), 1);
      check("lp_idle", 32'(busy), 0);

      // Stop mid-note, play+stop together, play while busy restarts.
      pulse_play();
      run(4);
      pulse_stop();
      check("st_hp", 32'(half_period), 0);
      check("st_busy", 32'(busy), 0);
      check("st_step", 32'(step), 0);
      check("st_end", 32'(song_end), 0);
      play = 1'b1; stop = 1'b1; tick(); play = 1'b0; stop = 1'b0;
      check("ps_busy", 32'(busy), 0);
      pulse_play();
      run(14);
      check("rs15_step", 32'(step), 1);
      pulse_play();
      check("rs16_step", 32'(step), 0);
      check("rs16_hp", 32'(half_period), 0);
      tick();
      check("rs17_hp", 32'(half_period), 11472);
      check("rs17_note", 32'(note), 3);
      pulse_stop();

      // Full table: 16 notes of 7 cycles each, end after step 15's gap.
      for (int a = 0; a < 16; a++) wr(a, 1, 1);
      pulse_play();
      end_cyc = -1; hcnt = 0;
      for (int c = 2; c <= 120; c++) begin
         tick();
         if (song_end) end_cyc = c;
         if (half_period == 15'd13636) hcnt++;
      end
      check("full_end_cyc", 32'(end_cyc), 113);
      check("full_hp_cycles", 32'(hcnt), 64);
      loop = 1'b1;
      pulse_play();
      wraps = 0; ends = 0; prev_step = step;
      for (int c = 2; c <= 230; c++) begin
         tick();
         if (prev_step == 4'd15 && step == 4'd0) wraps++;
         if (song_end) ends++;
         prev_step = step;
      end
      check("wrap_count", 32'(wraps), 2);
      check("wrap_noend", 32'(ends), 0);
      check("wrap_busy", 32'(busy), 1);
      pulse_stop();

      // Empty song with loop=1 must not hang.
      wr(0, 0, 0);
      pulse_play();
      tick();
      check("empty_end", 32'(song_end), 1);
      check("empty_busy", 32'(busy), 0);
      tick();
      check("empty_end_clr", 32'(song_end), 0);

      // Async reset mid-note clears outputs at once and wipes the table.
      wr(0, 1, 1);
      pulse_play();
      run(2);
      check("prer_hp", 32'(half_period), 13636);
      #2; rst_n = 1'b0; #1;
      check("ar_hp", 32'(half_period), 0);
      check("ar_note", 32'(note), 0);
      check("ar_busy", 32'(busy), 0);
      check("ar_step", 32'(step), 0);
      model_reset();
      @(posedge clk); #3; rst_n = 1'b1;
      loop = 1'b0;
      pulse_play();
      tick();
      check("clr_tbl_end", 32'(song_end), 1);

      // Writes during playback: future entry changes, sounding entry does not.
      base_song();
      pulse_play();
      run(2);
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = {3'd5, 4'd1};
      tick();
      wr_en = 1'b0;
      run(16);
      check("wr_hp20", 32'(half_period), 9104);
      check("wr_note20", 32'(note), 5);
      run(10);
      loop = 1'b1;
      pulse_play();
      run(2);
      wr(0, 7, 3);
      tick();
      check("wr_own_hp", 32'(half_period), 11472);
      check("wr_own_note", 32'(note), 3);
      run(23);
      check("wr_reload_hp", 32'(half_period), 7662);
      pulse_stop();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         play    = ($urandom_range(63) == 0);
         stop    = ($urandom_range(127) == 0);
         if ($urandom_range(49) == 0) loop = ~loop;
         wr_en   = ($urandom_range(7) == 0);
         wr_addr = 4'($urandom_range(15));
         wr_data = 7'($urandom_range(127));
         tick();
      end
      play = 1'b0; stop = 1'b0; wr_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
